// File: rtl/symcount_pkg.sv
// Shared types and helpers for the symbol round controller: FSM states, count width, LFSR taps.
// Pure declarations; no latency or flow-control behaviour of its own.
package symcount_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int               COUNT_W   = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] count);
        return (count == COUNT_MAX) ? count : count + 8'd1;
    endfunction

    // One step of the right-shifting 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for a bouncy push button; press is a 1-cycle rising edge.
// Latency: 2 + DEBOUNCE_CYC cycles from raw edge to level/press; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic Clk100M,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/symbol_round_ctrl.sv
// Round controller: shows a pseudo-random symbol stream, counts MAGIC symbols and debounced presses.
// Latency: first symbol SYM_PERIOD cycles after start, stop one period after the last; no backpressure.
module symbol_round_ctrl
    import symcount_pkg::*;
#(
    parameter int               SYM_PERIOD   = 50_000_000,
    parameter int               NUM_SYMBOLS  = 32,
    parameter int               SYM_W        = 4,
    parameter logic [SYM_W-1:0] MAGIC        = SYM_W'(4'hA),
    parameter int               DEBOUNCE_CYC = 1_000_000,
    parameter logic [15:0]      LFSR_SEED    = 16'hACE1
) (
    input  logic               Clk100M,
    input  logic               Reset,
    input  logic               go,
    input  logic               userButton,
    output logic [SYM_W-1:0]   symbol,
    output logic               symbolValid,
    output logic               start,
    output logic               stop,
    output logic [COUNT_W-1:0] userCount,
    output logic [COUNT_W-1:0] magicSymbolCount,
    output logic               busy
);

    localparam int            TW         = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam int            IW         = $clog2(NUM_SYMBOLS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SYM_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_SYMBOLS);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] sym_timer;
    logic [IW-1:0] sym_idx;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic          go_q;
    logic          go_rise;
    logic          wrap;
    logic          start_next;
    logic          stop_next;
    logic          sym_step;
    logic          btn_level;
    logic          btn_press;
    logic          counted_press;

    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .Clk100M(Clk100M),
        .Reset  (Reset),
        .raw    (userButton),
        .level  (btn_level),
        .press  (btn_press)
    );

    assign go_rise       = go & ~go_q;
    assign wrap          = (sym_timer == TIMER_LAST);
    assign lfsr_next     = lfsr_step(lfsr);
    assign counted_press = btn_press & btn_level;
    assign busy          = (state == RUN);

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_next = 1'b0;
        stop_next  = 1'b0;
        sym_step   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go_rise) begin
                    state_next = RUN;
                    start_next = 1'b1;
                end
            end
            RUN: begin
                // The wrap after the last symbol is the grace period that ends the round.
                if (wrap) begin
                    if (sym_idx == IDX_LAST) begin
                        stop_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        sym_step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            go_q             <= 1'b0;
            start            <= 1'b0;
            stop             <= 1'b0;
            symbolValid      <= 1'b0;
            symbol           <= '0;
            sym_timer        <= '0;
            sym_idx          <= '0;
            lfsr             <= LFSR_SEED;
            userCount        <= '0;
            magicSymbolCount <= '0;
        end else begin
            go_q        <= go;
            start       <= start_next;
            stop        <= stop_next;
            symbolValid <= sym_step;
            if (start_next) begin
                sym_timer        <= '0;
                sym_idx          <= '0;
                userCount        <= '0;
                magicSymbolCount <= '0;
            end else if (state == RUN) begin
                sym_timer <= wrap ? '0 : sym_timer + 1'b1;
                if (sym_step) begin
                    lfsr    <= lfsr_next;
                    symbol  <= lfsr_next[SYM_W-1:0];
                    sym_idx <= sym_idx + 1'b1;
                    if (lfsr_next[SYM_W-1:0] == MAGIC) begin
                        magicSymbolCount <= sat_inc(magicSymbolCount);
                    end
                end
                if (counted_press) begin
                    userCount <= sat_inc(userCount);
                end
            end
        end
    end

endmodule

// File: tb/tb_symbol_round_ctrl.sv
// Bench for symbol_round_ctrl: scoreboarded symbol stream, round timing, presses, saturation, reset abort.
// A second, long-round instance exercises the saturating counters.
module tb_symbol_round_ctrl;

    localparam int          SP     = 4;
    localparam int          NS     = 8;
    localparam int          DB     = 3;
    localparam logic [3:0]  MG     = 4'h8;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          SAT_SP = 8;
    localparam int          SAT_NS = 700;
    localparam int          ROUND  = (NS + 1) * SP;

    logic       Clk100M = 1'b0;
    logic       Reset = 1'b0;
    logic       go = 1'b0;
    logic       userButton = 1'b0;
    logic [3:0] symbol;
    logic       symbolValid, start, stop, busy;
    logic [7:0] userCount, magicSymbolCount;

    logic       sat_go = 1'b0;
    logic       sat_button = 1'b0;
    logic [0:0] sat_symbol;
    logic       sat_valid, sat_start, sat_stop, sat_busy;
    logic [7:0] sat_user, sat_magic;

    logic [23:0] all_out;
    logic [20:0] sat_all;
    assign all_out = {symbol, symbolValid, start, stop, userCount, magicSymbolCount, busy};
    assign sat_all = {sat_symbol, sat_valid, sat_start, sat_stop, sat_user, sat_magic, sat_busy};

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] model_lfsr;

    typedef struct {
        logic [3:0] sym;
        int         off;
    } exp_sym_t;
    exp_sym_t sb[$];

    symbol_round_ctrl #(
        .SYM_PERIOD(SP), .NUM_SYMBOLS(NS), .SYM_W(4), .MAGIC(MG),
        .DEBOUNCE_CYC(DB), .LFSR_SEED(SEED)
    ) dut (
        .Clk100M(Clk100M), .Reset(Reset), .go(go), .userButton(userButton),
        .symbol(symbol), .symbolValid(symbolValid), .start(start), .stop(stop),
        .userCount(userCount), .magicSymbolCount(magicSymbolCount), .busy(busy)
    );

    symbol_round_ctrl #(
        .SYM_PERIOD(SAT_SP), .NUM_SYMBOLS(SAT_NS), .SYM_W(1), .MAGIC(1'b1),
        .DEBOUNCE_CYC(DB), .LFSR_SEED(SEED)
    ) u_sat (
        .Clk100M(Clk100M), .Reset(Reset), .go(sat_go), .userButton(sat_button),
        .symbol(sat_symbol), .symbolValid(sat_valid), .start(sat_start), .stop(sat_stop),
        .userCount(sat_user), .magicSymbolCount(sat_magic), .busy(sat_busy)
    );

    always #5 Clk100M = ~Clk100M;

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic tick();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic test_reset();
        #3 Reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 24'h0) $display("FAIL reset_async: outputs=%h expected 000000", all_out);
        else n_pass++;
        n_checks++;
        if (sat_all !== 21'h0) $display("FAIL reset_async_sat: outputs=%h expected 0", sat_all);
        else n_pass++;
        repeat (3) @(posedge Clk100M);
        #3 Reset = 1'b0;
        model_lfsr = SEED;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_checks++;
            if (all_out !== 24'h0) $display("FAIL idle_quiet cyc %0d: outputs=%h expected 000000", i, all_out);
            else n_pass++;
        end
    endtask

    task automatic test_round();
        exp_sym_t e;
        int hits = 0;
        int stop_at = -1;
        for (int i = 0; i < NS; i++) begin
            model_lfsr = ref_step(model_lfsr);
            e.sym = model_lfsr[3:0];
            e.off = SP * (i + 1);
            sb.push_back(e);
            if (e.sym == MG) hits++;
        end
        go = 1'b1;
        tick();
        n_checks++;
        if (start !== 1'b1 || busy !== 1'b1) $display("FAIL round_start: start=%b busy=%b expected 1 1", start, busy);
        else n_pass++;
        go = 1'b0;
        for (int c = 1; c <= ROUND + 8 && stop_at < 0; c++) begin
            tick();
            if (symbolValid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL round_extra_symbol: symbolValid at cyc %0d, expected none", c);
                end else begin
                    e = sb.pop_front();
                    if (symbol !== e.sym || c != e.off)
                        $display("FAIL round_symbol: got %h at cyc %0d, expected %h at cyc %0d", symbol, c, e.sym, e.off);
                    else n_pass++;
                end
            end
            if (stop) stop_at = c;
        end
        n_checks++;
        if (stop_at != ROUND) $display("FAIL round_stop_time: stop at %0d expected %0d", stop_at, ROUND);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL round_missing_symbols: %0d left, expected 0", sb.size());
        else n_pass++;
        n_checks++;
        if (magicSymbolCount !== 8'(hits) || busy !== 1'b0 || userCount !== 8'd0)
            $display("FAIL round_counts: magic=%0d busy=%b user=%0d expected %0d 0 0", magicSymbolCount, busy, userCount, hits);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_presses();
        int stop_at = -1;
        logic [7:0] at_stop = 8'hxx;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= ROUND + 8 && stop_at < 0; c++) begin
            userButton = (c >= 2 && c <= 25) && (((c - 2) % 8) < 4);
            tick();
            if (stop) stop_at = c;
        end
        userButton = 1'b0;
        n_checks++;
        if (stop_at != ROUND || userCount !== 8'd3)
            $display("FAIL clean_presses: stop at %0d user=%0d expected %0d 3", stop_at, userCount, ROUND);
        else n_pass++;
        userButton = 1'b1;
        repeat (6) tick();
        userButton = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (userCount !== 8'd3 || busy !== 1'b0) $display("FAIL press_in_done: user=%0d busy=%b expected 3 0", userCount, busy);
        else n_pass++;
        // Bouncy press early, then a press timed to land exactly in the stop cycle.
        stop_at = -1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            userButton = (c == 2) || (c >= 4 && c <= 8) || (c >= 32 && c <= 39);
            tick();
            if (stop) begin
                stop_at = c;
                at_stop = userCount;
            end
        end
        userButton = 1'b0;
        n_checks++;
        if (stop_at != ROUND || at_stop !== 8'd1)
            $display("FAIL bouncy_press: stop at %0d user=%0d expected %0d 1", stop_at, at_stop, ROUND);
        else n_pass++;
        repeat (6) tick();
        n_checks++;
        if (userCount !== 8'd1) $display("FAIL press_in_stop_cycle: user=%0d expected 1", userCount);
        else n_pass++;
    endtask

    task automatic test_go_rules();
        int stop_at = -1;
        int extra_start = 0;
        go = 1'b1;
        tick();
        n_checks++;
        if (start !== 1'b1) $display("FAIL go_start: start=%b expected 1", start);
        else n_pass++;
        for (int c = 1; c <= ROUND + 8 && stop_at < 0; c++) begin
            go = (c >= 6 && c <= 10);
            userButton = (c >= 2 && c <= 6);
            tick();
            if (start) extra_start++;
            if (stop) stop_at = c;
        end
        go = 1'b0;
        userButton = 1'b0;
        n_checks++;
        if (extra_start != 0 || stop_at != ROUND || userCount !== 8'd1)
            $display("FAIL go_in_run: starts=%0d stop at %0d user=%0d expected 0 %0d 1", extra_start, stop_at, userCount, ROUND);
        else n_pass++;
        repeat (3) tick();
        go = 1'b1;
        tick();
        n_checks++;
        if (start !== 1'b1 || busy !== 1'b1 || stop !== 1'b0 || userCount !== 8'd0 || magicSymbolCount !== 8'd0)
            $display("FAIL go_in_done: start=%b busy=%b stop=%b user=%0d magic=%0d expected 1 1 0 0 0",
                     start, busy, stop, userCount, magicSymbolCount);
        else n_pass++;
        go = 1'b0;
        stop_at = -1;
        for (int c = 1; c <= ROUND + 8 && stop_at < 0; c++) begin
            tick();
            if (stop) stop_at = c;
        end
        n_checks++;
        if (stop_at != ROUND) $display("FAIL back_to_back_stop: stop at %0d expected %0d", stop_at, ROUND);
        else n_pass++;
    endtask

    task automatic test_reset_midround();
        exp_sym_t e;
        int hits = 0;
        int stop_at = -1;
        int extra_start = 0;
        go = 1'b1;
        tick();
        repeat (20) tick();
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 24'h0) $display("FAIL reset_midround: outputs=%h expected 000000", all_out);
        else n_pass++;
        repeat (2) @(posedge Clk100M);
        #3 Reset = 1'b0;
        model_lfsr = SEED;
        for (int i = 0; i < NS; i++) begin
            model_lfsr = ref_step(model_lfsr);
            e.sym = model_lfsr[3:0];
            e.off = SP * (i + 1);
            sb.push_back(e);
            if (e.sym == MG) hits++;
        end
        tick();
        n_checks++;
        if (start !== 1'b1 || busy !== 1'b1) $display("FAIL go_held_through_reset: start=%b busy=%b expected 1 1", start, busy);
        else n_pass++;
        for (int c = 1; c <= ROUND + 8 && stop_at < 0; c++) begin
            tick();
            if (start) extra_start++;
            if (symbolValid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL restart_extra_symbol: symbolValid at cyc %0d, expected none", c);
                end else begin
                    e = sb.pop_front();
                    if (symbol !== e.sym || c != e.off)
                        $display("FAIL restart_symbol: got %h at cyc %0d, expected %h at cyc %0d", symbol, c, e.sym, e.off);
                    else n_pass++;
                end
            end
            if (stop) stop_at = c;
        end
        go = 1'b0;
        n_checks++;
        if (stop_at != ROUND || extra_start != 0 || sb.size() != 0 || magicSymbolCount !== 8'(hits))
            $display("FAIL restart_round: stop at %0d starts=%0d left=%0d magic=%0d expected %0d 0 0 %0d",
                     stop_at, extra_start, sb.size(), magicSymbolCount, ROUND, hits);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_saturation();
        logic [15:0] l = SEED;
        int hits = 0;
        int cyc = 0;
        int stop_at = -1;
        for (int i = 0; i < SAT_NS; i++) begin
            l = ref_step(l);
            if (l[0]) hits++;
        end
        sat_go = 1'b1;
        tick();
        n_checks++;
        if (sat_start !== 1'b1) $display("FAIL sat_start: start=%b expected 1", sat_start);
        else n_pass++;
        sat_go = 1'b0;
        for (int k = 0; k < 300; k++) begin
            sat_button = 1'b1;
            repeat (5) begin tick(); cyc++; if (sat_stop) stop_at = cyc; end
            sat_button = 1'b0;
            repeat (5) begin tick(); cyc++; if (sat_stop) stop_at = cyc; end
        end
        while (stop_at < 0 && cyc < (SAT_NS + 1) * SAT_SP + 50) begin
            tick();
            cyc++;
            if (sat_stop) stop_at = cyc;
        end
        n_checks++;
        if (stop_at != (SAT_NS + 1) * SAT_SP) $display("FAIL sat_stop_time: stop at %0d expected %0d", stop_at, (SAT_NS + 1) * SAT_SP);
        else n_pass++;
        n_checks++;
        if (sat_user !== 8'd255) $display("FAIL sat_user: user=%0d expected 255", sat_user);
        else n_pass++;
        n_checks++;
        if (sat_magic !== ((hits > 255) ? 8'd255 : 8'(hits)))
            $display("FAIL sat_magic: magic=%0d expected %0d", sat_magic, (hits > 255) ? 255 : hits);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round();
        test_presses();
        test_go_rules();
        test_reset_midround();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
